div_unit: RTL and testbench

Multicycle 32-bit divider that produces the quotient and remainder for the MIPS `div` instruction. The quotient feeds the LO-source multiplexer as its divide input, selected for LO. The remainder feeds the matching HI-source multiplexer. The control unit starts the divider with a one-cycle pulse and waits for `done` before writing HI/LO. Division is radix-2 restoring, one quotient bit per cycle, applied to operand magnitudes, followed by a sign-fix step.

---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multicycle 32-bit radix-2 restoring divider for MIPS div/divu: quotient to LO, remainder to HI.
// Optional build macro DIV_UNSIGNED_EN adds the is_unsigned port for divu support.
module div_unit (
    input  logic        clk,
    input  logic        reset,
`ifdef DIV_UNSIGNED_EN
    input  logic        is_unsigned,
`endif
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] div_low_data,
    output logic [31:0] div_high_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;

    logic        uns;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        fits;
    logic [31:0] diff;

`ifdef DIV_UNSIGNED_EN
    assign uns = is_unsigned;
`else
    assign uns = 1'b0;
`endif

    always_comb begin
        a_neg = ~uns & dividend[31];
        b_neg = ~uns & divisor[31];
        a_mag = a_neg ? (~dividend + 32'd1) : dividend;
        b_mag = b_neg ? (~divisor + 32'd1) : divisor;
    end

    // 33-bit trial subtract split into compare + low-word difference; the
    // difference is below the divisor whenever it is kept, so 32 bits suffice.
    always_comb begin
        fits = {rem_q, quo_q[31]} >= {1'b0, dvs_q};
        diff = {rem_q[30:0], quo_q[31]} - dvs_q;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = 1'b0;
                    // A zero divisor passes through FIX so div_zero and done rise one edge later.
                    state_d = (divisor == '0) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                quo_d = {quo_q[30:0], fits};
                rem_d = fits ? diff : {rem_q[30:0], quo_q[31]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dvs_q == '0) begin
                    dz_d = 1'b1;
                end else begin
                    lo_d = qneg_q ? (~quo_q + 32'd1) : quo_q;
                    hi_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign div_low_data  = lo_q;
    assign div_high_data = hi_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign div_zero      = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: signed cases, divide by zero, overflow,
// start-while-busy, mid-run reset, and divu when DIV_UNSIGNED_EN is defined.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_low_data;
    logic [31:0] div_high_data;
    logic        busy;
    logic        done;
    logic        div_zero;
`ifdef DIV_UNSIGNED_EN
    logic        is_unsigned;
`endif

    int n_checks;
    int n_pass;

    div_unit dut (
        .clk          (clk),
        .reset        (reset),
`ifdef DIV_UNSIGNED_EN
        .is_unsigned  (is_unsigned),
`endif
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_low_data (div_low_data),
        .div_high_data(div_high_data),
        .busy         (busy),
        .done         (done),
        .div_zero     (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle, optionally re-pulse start at busy cycle inj,
    // and return the number of edges after the start edge until done is seen.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic uns,
                           input int inj, output int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef DIV_UNSIGNED_EN
        is_unsigned = uns;
`else
        if (uns) $display("note: unsigned request ignored in signed-only build");
`endif
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == inj) begin
                start    = 1'b1;
                dividend = 32'd1000;
                divisor  = 32'd3;
            end
        end
        start = 1'b0;
    endtask

    int lat;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_UNSIGNED_EN
        is_unsigned = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_lo",   div_low_data, 32'd0);
        check("rst_hi",   div_high_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz",   {31'd0, div_zero}, 32'd0);

        // 100 / 7
        run_div(32'd100, 32'd7, 1'b0, -1, lat);
        check("pos_lat", lat, 33);
        check("pos_lo",  div_low_data, 32'd14);
        check("pos_hi",  div_high_data, 32'd2);
        check("pos_dz",  {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        check("pos_idle", {31'd0, busy}, 32'd0);
        check("pos_hold", div_low_data, 32'd14);

        // -100 / 7 and 100 / -7
        run_div(32'hFFFF_FF9C, 32'd7, 1'b0, -1, lat);
        check("negA_lo", div_low_data, 32'hFFFF_FFF2);
        check("negA_hi", div_high_data, 32'hFFFF_FFFE);
        run_div(32'd100, 32'hFFFF_FFF9, 1'b0, -1, lat);
        check("negB_lo", div_low_data, 32'hFFFF_FFF2);
        check("negB_hi", div_high_data, 32'd2);

        // Divide by zero after reloading 100/7
        run_div(32'd100, 32'd7, 1'b0, -1, lat);
        run_div(32'd5, 32'd0, 1'b0, -1, lat);
        check("dz_lat", lat, 1);
        check("dz_flag", {31'd0, div_zero}, 32'd1);
        check("dz_lo", div_low_data, 32'd14);
        check("dz_hi", div_high_data, 32'd2);
        @(negedge clk);
        check("dz_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("dz_sticky", {31'd0, div_zero}, 32'd1);

        // Signed overflow; also clears the sticky flag
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, lat);
        check("ovf_lat", lat, 33);
        check("ovf_lo", div_low_data, 32'h8000_0000);
        check("ovf_hi", div_high_data, 32'd0);
        check("ovf_dz", {31'd0, div_zero}, 32'd0);

        // Start while busy is ignored
        run_div(32'd1234567, 32'd1000, 1'b0, 10, lat);
        check("busy_lat", lat, 33);
        check("busy_lo", div_low_data, 32'd1234);
        check("busy_hi", div_high_data, 32'd567);
        @(negedge clk);
        check("busy_noretrig", {31'd0, busy}, 32'd0);

        // Reset mid-RUN
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_lo",   div_low_data, 32'd0);
        check("mrst_hi",   div_high_data, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);

        run_div(32'd9, 32'd3, 1'b0, -1, lat);
        check("post_lat", lat, 33);
        check("post_lo", div_low_data, 32'd3);
        check("post_hi", div_high_data, 32'd0);

`ifdef DIV_UNSIGNED_EN
        run_div(32'hFFFF_FFFF, 32'd2, 1'b1, -1, lat);
        check("uns_lat", lat, 33);
        check("uns_lo", div_low_data, 32'h7FFF_FFFF);
        check("uns_hi", div_high_data, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
